// File: rtl/eth_rx_crc_check.sv
// eth_rx_crc_check
// Receive-side Ethernet frame checker on the 4-bit MII datapath.
// Strips preamble/SFD, packs nibbles (low first) into bytes and runs the
// reflected CRC-32 over every nibble after the SFD. A 4-byte delay line
// holds back the FCS so only payload bytes reach the MAC receive logic.
// Per-frame status is reported with a one-cycle frame_done strobe.
//
// Ports:
//   clk          MII receive clock, rising edge
//   reset        synchronous, active-high
//   rx_dv        MII receive data valid
//   rx_er        MII receive error
//   rxd[3:0]     MII receive nibble
//   data_out     payload byte (FCS excluded), qualified by data_valid
//   data_valid   one-cycle strobe per payload byte
//   frame_done   one-cycle end-of-frame strobe; status below valid with it
//   frame_ok     no crc_err, align_err, rx_err_seen or len_err
//   crc_err      CRC residue mismatch
//   align_err    odd nibble count after SFD
//   rx_err_seen  rx_er seen during frame data
//   len_err      frame length outside 64..1518 (only with ETH_RX_LEN_CHECK_EN)
//   frame_len    bytes after SFD including FCS, saturating at 2047
//
// Configuration macro: ETH_RX_LEN_CHECK_EN enables the length check.
// Without it len_err is tied low and frame_ok ignores the length.

module eth_rx_crc_check (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rxd,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        align_err,
    output logic        rx_err_seen,
    output logic        len_err,
    output logic [10:0] frame_len
);

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    // Register value left after the FCS itself has been clocked through
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [10:0] LEN_MAX       = 11'd2047;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state, state_next;
    logic        start_frame, end_frame, data_nib, byte_done;
    logic        len_bad, crc_bad;

    logic [31:0] crc_q;
    logic        nib_hi_q;      // low nibble held, next nibble completes a byte
    logic [3:0]  low_nib_q;
    logic [10:0] len_q;
    logic [2:0]  dl_cnt_q;      // bytes currently held in the delay line (0..4)
    logic        rx_err_q;
    logic [7:0]  dl_q [0:3];

    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else             c = c >> 1;
        end
        return c;
    endfunction

`ifdef ETH_RX_LEN_CHECK_EN
    assign len_bad = (len_q < 11'd64) || (len_q > 11'd1518);
`else
    assign len_bad = 1'b0;
`endif

    assign crc_bad   = (crc_q != CRC_RESIDUE);
    assign byte_done = data_nib & nib_hi_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        data_nib    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) state_next = (rxd == 4'h5) ? PREAMBLE : DROP;
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                end else if (rxd == 4'hD) begin
                    state_next  = DATA;
                    start_frame = 1'b1;
                end else if (rxd != 4'h5) begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_next = IDLE;
                    end_frame  = 1'b1;
                end else begin
                    data_nib = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control, CRC and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q       <= CRC_INIT;
            nib_hi_q    <= 1'b0;
            len_q       <= '0;
            dl_cnt_q    <= '0;
            rx_err_q    <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            crc_err     <= 1'b0;
            align_err   <= 1'b0;
            rx_err_seen <= 1'b0;
            len_err     <= 1'b0;
            frame_len   <= '0;
        end else begin
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            crc_err     <= 1'b0;
            align_err   <= 1'b0;
            rx_err_seen <= 1'b0;
            len_err     <= 1'b0;
            frame_len   <= '0;

            if (start_frame) begin
                crc_q    <= CRC_INIT;
                nib_hi_q <= 1'b0;
                len_q    <= '0;
                dl_cnt_q <= '0;
                rx_err_q <= 1'b0;
            end

            if (data_nib) begin
                // Every nibble feeds the CRC, including a trailing odd one
                crc_q    <= crc_nibble(crc_q, rxd);
                nib_hi_q <= ~nib_hi_q;
                if (rx_er) rx_err_q <= 1'b1;
            end

            if (byte_done) begin
                if (len_q != LEN_MAX) len_q <= len_q + 11'd1;
                // Oldest byte leaves only once four newer bytes exist
                if (dl_cnt_q == 3'd4) begin
                    data_out   <= dl_q[3];
                    data_valid <= 1'b1;
                end else begin
                    dl_cnt_q <= dl_cnt_q + 3'd1;
                end
            end

            if (end_frame) begin
                frame_done  <= 1'b1;
                crc_err     <= crc_bad;
                align_err   <= nib_hi_q;
                rx_err_seen <= rx_err_q;
                len_err     <= len_bad;
                frame_len   <= len_q;
                frame_ok    <= ~(crc_bad | nib_hi_q | rx_err_q | len_bad);
            end
        end
    end

    // Byte assembly and FCS hold-back delay line
    always_ff @(posedge clk) begin
        if (data_nib && !nib_hi_q) low_nib_q <= rxd;
        if (byte_done) begin
            dl_q[0] <= {rxd, low_nib_q};
            dl_q[1] <= dl_q[0];
            dl_q[2] <= dl_q[1];
            dl_q[3] <= dl_q[2];
        end
    end

endmodule

// File: tb/tb_eth_rx_crc_check.sv
// tb_eth_rx_crc_check
// Directed bench for eth_rx_crc_check: builds frames with a correct FCS,
// drives them nibble by nibble on the MII inputs and compares the emitted
// payload bytes and per-frame status against hand-derived expectations.

module tb_eth_rx_crc_check;

`ifdef ETH_RX_LEN_CHECK_EN
    localparam logic LEN_EN = 1'b1;
`else
    localparam logic LEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic        rx_er;
    logic [3:0]  rxd;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        align_err;
    logic        rx_err_seen;
    logic        len_err;
    logic [10:0] frame_len;

    eth_rx_crc_check dut (
        .clk         (clk),
        .reset       (reset),
        .rx_dv       (rx_dv),
        .rx_er       (rx_er),
        .rxd         (rxd),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .crc_err     (crc_err),
        .align_err   (align_err),
        .rx_err_seen (rx_err_seen),
        .len_err     (len_err),
        .frame_len   (frame_len)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic        ok;
        logic        crc;
        logic        align;
        logic        rxe;
        logic        len;
        logic [10:0] flen;
    } status_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          first_dv_cyc = -1;
    int          fd_cyc = -1;
    int          hi4_cyc = -1;
    int          end_cyc = -1;
    int          coincide = 0;
    int          stale = 0;
    logic        fd_prev = 1'b0;
    logic [7:0]  rx_q [$];
    status_t     fd_q [$];
    logic [7:0]  fb [0:2199];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        status_t s;
        if (data_valid) begin
            rx_q.push_back(data_out);
            if (first_dv_cyc < 0) first_dv_cyc = cyc;
        end
        if (frame_done) begin
            s = '{ok: frame_ok, crc: crc_err, align: align_err, rxe: rx_err_seen,
                  len: len_err, flen: frame_len};
            fd_q.push_back(s);
            fd_cyc = cyc;
        end
        if (data_valid && frame_done) coincide++;
        if (fd_prev && (frame_done | frame_ok | crc_err | align_err | rx_err_seen |
                        len_err | (frame_len != 11'd0))) stale++;
        fd_prev = frame_done;
    end

    // Payload 0,1,2,... followed by the FCS (complemented reflected CRC, LSB byte first)
    task automatic build_frame(input int n_payload);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n_payload; i++) begin
            fb[i] = i[7:0];
            c = c ^ {24'h0, fb[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) fb[n_payload + k] = c[8*k +: 8];
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic er);
        @(negedge clk);
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        fd_q.delete();
        first_dv_cyc = -1;
        fd_cyc = -1;
    endtask

    task automatic send_frame(input int nbytes, input int er_byte, input int rst_byte,
                              input logic extra_nib);
        for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            if (i == rst_byte) begin
                @(negedge clk);
                reset = 1'b1;
                rx_dv = 1'b1;
                rxd   = fb[i][3:0];
                @(negedge clk);
                reset = 1'b0;
                rx_dv = 1'b0;
                check_val("mid reset data_valid", data_valid, 0);
                check_val("mid reset frame_done", frame_done, 0);
                return;
            end
            drive(1'b1, fb[i][3:0], i == er_byte);
            drive(1'b1, fb[i][7:4], 1'b0);
            if (i == 4) hi4_cyc = cyc;
        end
        if (extra_nib) drive(1'b1, 4'h0, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        end_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0);
    endtask

    task automatic check_data(input string tag, input int n);
        int errs;
        errs = 0;
        check_val({tag, " count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            if (rx_q[i] !== fb[i]) errs++;
        check_val({tag, " bytes"}, errs, 0);
    endtask

    // exp_crc < 0 means the CRC flag is not checked for this frame
    task automatic check_status(input string tag, input logic ok, input int exp_crc,
                                input logic align, input logic rxe, input logic len,
                                input int flen);
        check_val({tag, " frames"}, fd_q.size(), 1);
        if (fd_q.size() >= 1) begin
            check_val({tag, " frame_ok"}, fd_q[0].ok, ok);
            if (exp_crc >= 0) check_val({tag, " crc_err"}, fd_q[0].crc, exp_crc);
            check_val({tag, " align_err"}, fd_q[0].align, align);
            check_val({tag, " rx_err_seen"}, fd_q[0].rxe, rxe);
            check_val({tag, " len_err"}, fd_q[0].len, len);
            check_val({tag, " frame_len"}, fd_q[0].flen, flen);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 4'h0;
        repeat (3) @(negedge clk);
        check_val("reset data_valid", data_valid, 0);
        check_val("reset frame_done", frame_done, 0);
        check_val("reset status", {frame_ok, crc_err, align_err, rx_err_seen, len_err}, 0);
        check_val("reset frame_len", frame_len, 0);
        check_val("reset data_out", data_out, 0);
        reset = 1'b0;
        idle(2);

        // Valid 64-byte frame
        build_frame(60);
        clear_mon();
        send_frame(64, -1, -1, 1'b0);
        idle(4);
        check_status("valid64", 1'b1, 0, 1'b0, 1'b0, 1'b0, 64);
        check_data("valid64", 60);
        check_val("valid64 first byte latency", first_dv_cyc, hi4_cyc + 1);
        check_val("valid64 frame_done latency", fd_cyc, end_cyc + 1);

        // Bit 0 of byte 10 flipped after the FCS was computed
        build_frame(60);
        fb[10] = fb[10] ^ 8'h01;
        clear_mon();
        send_frame(64, -1, -1, 1'b0);
        idle(4);
        check_status("badcrc", 1'b0, 1, 1'b0, 1'b0, 1'b0, 64);
        check_data("badcrc", 60);

        // One trailing nibble after a valid frame
        build_frame(60);
        clear_mon();
        send_frame(64, -1, -1, 1'b1);
        idle(4);
        check_status("align", 1'b0, -1, 1'b1, 1'b0, 1'b0, 64);
        check_data("align", 60);

        // rx_er for one nibble at byte 20
        clear_mon();
        send_frame(64, 20, -1, 1'b0);
        idle(4);
        check_status("rxer", 1'b0, 0, 1'b0, 1'b1, 1'b0, 64);

        // Short 40-byte frame
        build_frame(36);
        clear_mon();
        send_frame(40, -1, -1, 1'b0);
        idle(4);
        check_status("short40", ~LEN_EN, 0, 1'b0, 1'b0, LEN_EN, 40);
        check_data("short40", 36);

        // Reset at byte 30, then a clean frame
        build_frame(60);
        clear_mon();
        send_frame(64, -1, 30, 1'b0);
        idle(4);
        check_val("reset abort frames", fd_q.size(), 0);
        clear_mon();
        send_frame(64, -1, -1, 1'b0);
        idle(4);
        check_status("after reset", 1'b1, 0, 1'b0, 1'b0, 1'b0, 64);
        check_data("after reset", 60);

        // Bad preamble nibble, then an SFD-like nibble and data while dropping
        clear_mon();
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'h7, 1'b0);
        drive(1'b1, 4'h5, 1'b0);
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, i[3:0], 1'b0);
        idle(4);
        // Frame starting with a non-preamble nibble
        drive(1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 4'hA, 1'b0);
        idle(4);
        check_val("drop data strobes", rx_q.size(), 0);
        check_val("drop frames", fd_q.size(), 0);

        // Back-to-back frames: preamble starts the cycle after frame_done
        clear_mon();
        send_frame(64, -1, -1, 1'b0);
        drive(1'b0, 4'h0, 1'b0);
        send_frame(64, -1, -1, 1'b0);
        idle(4);
        check_val("b2b frames", fd_q.size(), 2);
        if (fd_q.size() == 2) begin
            check_val("b2b first ok", fd_q[0].ok, 1);
            check_val("b2b second ok", fd_q[1].ok, 1);
            check_val("b2b second len", fd_q[1].flen, 64);
        end
        check_val("b2b data count", rx_q.size(), 120);
        if (rx_q.size() == 120) check_val("b2b second frame byte 59", rx_q[119], 8'h3B);

        // Long frame: frame_len saturates, payload keeps streaming
        build_frame(2096);
        clear_mon();
        send_frame(2100, -1, -1, 1'b0);
        idle(4);
        check_status("long", ~LEN_EN, 0, 1'b0, 1'b0, LEN_EN, 2047);
        check_data("long", 2096);

        check_val("data_valid with frame_done", coincide, 0);
        check_val("status not cleared", stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
